mips_multicycle_ctrl: RTL and testbench

Main control FSM for the multicycle MIPS datapath. It sequences the PC, instruction register, register file, ALU operand muxes (including the shift-left-2 branch-offset and jump-target paths) and memory across 3-5 cycles per instruction. It waits on a memory-ready handshake and flags unsupported opcodes.

---
 rtl/mips_multicycle_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - main control FSM for the multicycle MIPS datapath
//
// Sequences PC, IR, register file, ALU operand muxes and memory over 3-5
// cycles per instruction, stretching memory states while mem_ready is low.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   opcode[5:0]          instr[31:26] from the IR (valid from DECODE onward)
//   mem_ready            memory completes the current access this cycle
//   pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0],
//   alu_op[1:0], pc_source[1:0]   datapath control strobes
//   state[3:0]           current state, for debug
//   illegal_op           one-cycle pulse in DECODE on an unsupported opcode

module mips_multicycle_ctrl #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_ADDI  = 6'h08,
    parameter logic [5:0] OP_J     = 6'h02
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    always_comb begin
        state_d       = S_FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;

        case (state_q)
            S_FETCH: begin
                // PC+4 is computed every FETCH cycle but only committed
                // together with the IR load once the fetch completes.
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                state_d   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut while decoding.
                alu_src_b = 2'b11;
                if (opcode == OP_RTYPE) begin
                    state_d = S_EXEC;
                end else if (opcode == OP_LW || opcode == OP_SW) begin
                    state_d = S_MEMADR;
                end else if (opcode == OP_BEQ) begin
                    state_d = S_BRANCH;
                end else if (opcode == OP_ADDI) begin
                    state_d = S_ADDIEX;
                end else if (opcode == OP_J) begin
                    state_d = S_JUMP;
                end else begin
                    illegal_op = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                state_d  = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                state_d   = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - table-driven self-checking bench for mips_multicycle_ctrl

module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .state         (state),
        .illegal_op    (illegal_op)
    );

    // Control word: {illegal_op, pc_write, pc_write_cond, i_or_d, mem_read,
    // mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
    // alu_src_b[1:0], alu_op[1:0], pc_source[1:0]}
    wire [16:0] ctrl = {illegal_op, pc_write, pc_write_cond, i_or_d, mem_read,
                        mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
                        alu_src_a, alu_src_b, alu_op, pc_source};

    localparam logic [16:0] C_FSTALL = 17'h01010;
    localparam logic [16:0] C_FRDY   = 17'h09410;
    localparam logic [16:0] C_DEC    = 17'h00030;
    localparam logic [16:0] C_DECILL = 17'h10030;
    localparam logic [16:0] C_MADR   = 17'h00060;
    localparam logic [16:0] C_MRD    = 17'h03000;
    localparam logic [16:0] C_MWB    = 17'h00280;
    localparam logic [16:0] C_MWR    = 17'h02800;
    localparam logic [16:0] C_EXEC   = 17'h00048;
    localparam logic [16:0] C_ALUWB  = 17'h00180;
    localparam logic [16:0] C_BR     = 17'h04045;
    localparam logic [16:0] C_AEX    = 17'h00060;
    localparam logic [16:0] C_AWB    = 17'h00080;
    localparam logic [16:0] C_JMP    = 17'h08002;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  exp_state;
        logic [16:0] exp_ctrl;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [5:0] op, input logic rdy,
                       input logic [3:0] st, input logic [16:0] c);
        vec_t v;
        v.rst = rst; v.op = op; v.rdy = rdy; v.exp_state = st; v.exp_ctrl = c;
        vecs.push_back(v);
    endtask

    initial begin
        reset = 1'b1;
        opcode = 6'h00;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);

        // LW, no waits: 0,1,2,3,4
        add(0, 6'h23, 1, 0, C_FRDY);   add(0, 6'h23, 1, 1, C_DEC);
        add(0, 6'h23, 1, 2, C_MADR);   add(0, 6'h23, 1, 3, C_MRD);
        add(0, 6'h23, 1, 4, C_MWB);
        // SW with 3 wait cycles in MEMWR
        add(0, 6'h2B, 1, 0, C_FRDY);   add(0, 6'h2B, 1, 1, C_DEC);
        add(0, 6'h2B, 1, 2, C_MADR);   add(0, 6'h2B, 0, 5, C_MWR);
        add(0, 6'h2B, 0, 5, C_MWR);    add(0, 6'h2B, 0, 5, C_MWR);
        add(0, 6'h2B, 1, 5, C_MWR);
        // BEQ
        add(0, 6'h04, 1, 0, C_FRDY);   add(0, 6'h04, 1, 1, C_DEC);
        add(0, 6'h04, 1, 8, C_BR);
        // J then ADDI back-to-back
        add(0, 6'h02, 1, 0, C_FRDY);   add(0, 6'h02, 1, 1, C_DEC);
        add(0, 6'h02, 1, 11, C_JMP);
        add(0, 6'h08, 1, 0, C_FRDY);   add(0, 6'h08, 1, 1, C_DEC);
        add(0, 6'h08, 1, 9, C_AEX);    add(0, 6'h08, 1, 10, C_AWB);
        // R-type
        add(0, 6'h00, 1, 0, C_FRDY);   add(0, 6'h00, 1, 1, C_DEC);
        add(0, 6'h00, 1, 6, C_EXEC);   add(0, 6'h00, 1, 7, C_ALUWB);
        // FETCH stalled 4 cycles, then illegal opcode pulses once
        add(0, 6'h3F, 0, 0, C_FSTALL); add(0, 6'h3F, 0, 0, C_FSTALL);
        add(0, 6'h3F, 0, 0, C_FSTALL); add(0, 6'h3F, 0, 0, C_FSTALL);
        add(0, 6'h3F, 1, 0, C_FRDY);   add(0, 6'h3F, 1, 1, C_DECILL);
        add(0, 6'h00, 0, 0, C_FSTALL);
        // LW with a MEMRD wait; mem_ready low in DECODE/MEMADR is ignored
        add(0, 6'h23, 1, 0, C_FRDY);   add(0, 6'h23, 0, 1, C_DEC);
        add(0, 6'h23, 0, 2, C_MADR);   add(0, 6'h23, 0, 3, C_MRD);
        add(0, 6'h23, 1, 3, C_MRD);    add(0, 6'h23, 1, 4, C_MWB);
        add(0, 6'h00, 0, 0, C_FSTALL);
        // Reset held 2 cycles mid-MEMRD, released with mem_ready=1
        add(0, 6'h23, 1, 0, C_FRDY);   add(0, 6'h23, 1, 1, C_DEC);
        add(0, 6'h23, 1, 2, C_MADR);   add(0, 6'h23, 0, 3, C_MRD);
        add(1, 6'h23, 0, 3, C_MRD);    add(1, 6'h23, 0, 0, C_FSTALL);
        add(0, 6'h23, 1, 0, C_FRDY);   add(0, 6'h23, 1, 1, C_DEC);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst;
            opcode = vecs[i].op;
            mem_ready = vecs[i].rdy;
            #2;
            check($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].exp_state));
            check($sformatf("vec%0d ctrl", i), 32'(ctrl), 32'(vecs[i].exp_ctrl));
            check($sformatf("vec%0d exclusive", i),
                  32'({pc_write & pc_write_cond, mem_read & mem_write}), 32'(0));
        end

        // Finish the pending LW (now in MEMADR after DECODE) back to FETCH.
        @(negedge clk);
        mem_ready = 1'b1;
        for (int n = 0; n < 20 && state != 4'd0; n++) @(negedge clk);
        check("drain to fetch", 32'(state), 32'(0));

        // SW latency as a function of MEMWR wait cycles.
        for (int w = 0; w < 4; w++) begin
            int cyc;
            int wcnt;
            logic saw_rw;
            logic mw_ok;
            cyc = 0; wcnt = 0; saw_rw = 1'b0; mw_ok = 1'b1;
            opcode = 6'h2B;
            mem_ready = 1'b1;
            #2;
            do begin
                if (state == 4'd5) begin
                    mem_ready = (wcnt >= w);
                    wcnt++;
                    #1;
                    if (!mem_write) mw_ok = 1'b0;
                end else begin
                    mem_ready = 1'b1;
                end
                if (reg_write) saw_rw = 1'b1;
                @(negedge clk);
                #2;
                cyc++;
            end while (state != 4'd0 && cyc < 30);
            check($sformatf("sw latency w=%0d", w), 32'(cyc), 32'(4 + w));
            check($sformatf("sw memwr cycles w=%0d", w), 32'(wcnt), 32'(w + 1));
            check($sformatf("sw mem_write held w=%0d", w), 32'(mw_ok), 32'(1));
            check($sformatf("sw no reg_write w=%0d", w), 32'(saw_rw), 32'(0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
